// File: rtl/ads8865_responder.sv
// ADS8865 device-side model: CONVST-triggered conversion, busy timing and
// MSB-first serial readout with daisy-chain pass-through on sdi.
`timescale 1ns/1ps
module ads8865_responder #(
  parameter int BITS        = 16,
  parameter int CONV_CYCLES = 180
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cs,
  input  logic            sclk,
  input  logic            sdi,
  input  logic [BITS-1:0] sample,
  output logic            sdo,
  output logic            sdo_oe,
  output logic            busy,
  output logic            sample_taken
);

  localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int BW = $clog2(BITS + 1);
  localparam logic [CW-1:0] CNT_LOAD   = CW'(CONV_CYCLES - 1);
  localparam logic [BW-1:0] BIT_MAX    = BW'(BITS);
  localparam logic          START_TAKE = (CONV_CYCLES == 1);

  typedef enum logic [1:0] {IDLE, CONVERT, READY, SHIFT} state_t;

  state_t          state;
  logic [2:0]      cs_sync;
  logic [2:0]      sclk_sync;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bitcnt;
  logic [BITS-1:0] shreg;
  logic            cs_rise;
  logic            cs_low;
  logic            sclk_fall;

  // [0],[1] form the synchronizer, [2] is the edge-detect history flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync   <= '0;
      sclk_sync <= '0;
    end else begin
      cs_sync   <= {cs_sync[1:0], cs};
      sclk_sync <= {sclk_sync[1:0], sclk};
    end
  end

  always_comb begin
    cs_rise   = cs_sync[1] & ~cs_sync[2];
    cs_low    = ~cs_sync[1] & ~cs_sync[2];
    sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bitcnt       <= '0;
      shreg        <= '0;
      sdo          <= 1'b0;
      sdo_oe       <= 1'b0;
      busy         <= 1'b0;
      sample_taken <= 1'b0;
    end else begin
      sample_taken <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_rise) begin
            state        <= CONVERT;
            cnt          <= CNT_LOAD;
            busy         <= 1'b1;
            sample_taken <= START_TAKE;
          end
        end
        CONVERT: begin
          if (cnt == '0) begin
            shreg <= sample;
            busy  <= 1'b0;
            state <= READY;
          end else begin
            cnt          <= cnt - CW'(1);
            sample_taken <= (cnt == CW'(1));
          end
        end
        READY: begin
          if (cs_low) begin
            state  <= SHIFT;
            sdo_oe <= 1'b1;
            sdo    <= shreg[BITS-1];
            bitcnt <= '0;
          end
        end
        SHIFT: begin
          // a new conversion request takes priority over a coincident shift
          if (cs_rise) begin
            state        <= CONVERT;
            cnt          <= CNT_LOAD;
            busy         <= 1'b1;
            sample_taken <= START_TAKE;
            sdo_oe       <= 1'b0;
            sdo          <= 1'b0;
          end else begin
            sdo <= shreg[BITS-1];
            if (sclk_fall) begin
              shreg <= {shreg[BITS-2:0], sdi};
              if (bitcnt != BIT_MAX) bitcnt <= bitcnt + BW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
